// File: rtl/bus_mux_arbiter.sv
// bus_mux_arbiter: four-requester round-robin bus arbiter with a shared data mux.
// A requester owns the bus until it strobes done or drops req; every release is
// followed by one idle cycle before the next grant.
// Optional forced release (hold timeout) is compiled in with `define BUS_ARB_TIMEOUT_EN.
module bus_mux_arbiter #(
  parameter int WIDTH    = 64,
  parameter int MAX_HOLD = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            req,
  input  logic [3:0]            done,
  input  logic [3:0][WIDTH-1:0] in,
  output logic [WIDTH-1:0]      out,
  output logic [3:0]            gnt,
  output logic [1:0]            sel,
  output logic                  valid,
  output logic                  tmo
);

  // MAX_HOLD must fit the 8-bit hold counter and be at least one cycle.
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("bus_mux_arbiter: MAX_HOLD must be in 1..255");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q,   ptr_d;
  logic [3:0] gnt_q,   gnt_d;
  logic [1:0] sel_q,   sel_d;
  logic       valid_q, valid_d;
  logic       tmo_q,   tmo_d;

  logic       pick_found;
  logic [1:0] pick_idx;
  logic       normal_rel;
  logic       other_req;
  logic       hold_expired;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_q, hold_d;

  // Forced release once the owner has used its budget while someone else waits.
  // Compared with >= so that a grant that outlived the budget while alone is
  // still bounded as soon as contention appears.
  always_comb begin
    hold_expired = (hold_q >= HOLD_LAST) && other_req;
  end
`else
  // No timeout hardware: grants end only on done or req drop.
  always_comb begin
    hold_expired = 1'b0;
  end
`endif

  // Round-robin pick: first asserted req at or after ptr, wrapping modulo 4.
  always_comb begin
    logic [1:0] cand;
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    cand       = ptr_q;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Release qualifiers for the current owner; non-owners are masked out.
  always_comb begin
    normal_rel = done[sel_q] | ~req[sel_q];
    other_req  = |(req & ~(4'b0001 << sel_q));
  end

  // Next-state and next-output computation for the two-state FSM.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    tmo_d   = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
    hold_d  = hold_q;
`endif
    case (state_q)
      IDLE: begin
        gnt_d   = 4'b0000;
        valid_d = 1'b0;
        if (pick_found) begin
          state_d = OWNED;
          gnt_d   = 4'b0001 << pick_idx;
          sel_d   = pick_idx;
          valid_d = 1'b1;
          ptr_d   = pick_idx + 2'd1;
`ifdef BUS_ARB_TIMEOUT_EN
          hold_d  = 8'd0;
`endif
        end
      end
      OWNED: begin
        if (normal_rel || hold_expired) begin
          // A normal release taking effect on the same edge wins over the timeout.
          state_d = IDLE;
          gnt_d   = 4'b0000;
          valid_d = 1'b0;
          tmo_d   = hold_expired & ~normal_rel;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (hold_q != 8'hFF) begin
          hold_d = hold_q + 8'd1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops any grant without a tmo pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign valid = valid_q;
  assign tmo   = tmo_q;
  assign out   = valid_q ? in[sel_q] : '0;

endmodule

// File: tb/tb_bus_mux_arbiter.sv
// Self-checking bench for bus_mux_arbiter. Compiles with or without
// BUS_ARB_TIMEOUT_EN; timeout scenarios are only stimulated when it is defined.
module tb_bus_mux_arbiter;

  localparam int WIDTH    = 64;
  localparam int MAX_HOLD = 4;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset;
  logic [3:0]            req;
  logic [3:0]            done;
  logic [3:0][WIDTH-1:0] in;
  logic [WIDTH-1:0]      out;
  logic [3:0]            gnt;
  logic [1:0]            sel;
  logic                  valid;
  logic                  tmo;

  always #5 clk = ~clk;

  bus_mux_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done), .in(in),
    .out(out), .gnt(gnt), .sel(sel), .valid(valid), .tmo(tmo)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;

  // Behavioural model: who owns the bus (-1 = nobody), last owner, rotation
  // pointer, cycles held so far, and whether the last release was forced.
  int m_owner = -1;
  int m_last  = 0;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_tmo   = 1'b0;

  task automatic model_step();
    bit normal, others, forced;
    if (reset) begin
      m_owner = -1; m_last = 0; m_ptr = 0; m_held = 0; m_tmo = 1'b0;
      return;
    end
    m_tmo = 1'b0;
    if (m_owner < 0) begin
      for (int i = 0; i < 4; i++) begin
        int c;
        c = (m_ptr + i) % 4;
        if (req[c]) begin
          m_owner = c; m_last = c; m_ptr = (c + 1) % 4; m_held = 0;
          break;
        end
      end
    end else begin
      normal = done[m_owner] || !req[m_owner];
      others = 1'b0;
      for (int j = 0; j < 4; j++) if (j != m_owner && req[j]) others = 1'b1;
      forced = TMO_EN && (m_held >= MAX_HOLD - 1) && others;
      if (normal || forced) begin
        m_owner = -1;
        m_tmo   = forced && !normal;
      end else if (m_held < 255) begin
        m_held++;
      end
    end
  endtask

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, cycle, act, exp);
    end
  endtask

  task automatic compare_all();
    logic [3:0]       e_gnt;
    logic [WIDTH-1:0] e_out;
    e_gnt = 4'b0000;
    e_out = '0;
    if (m_owner >= 0) begin
      e_gnt[m_owner] = 1'b1;
      e_out = in[m_owner];
    end
    check("gnt",   WIDTH'(gnt),   WIDTH'(e_gnt));
    check("sel",   WIDTH'(sel),   WIDTH'(m_last));
    check("valid", WIDTH'(valid), WIDTH'(m_owner >= 0));
    check("tmo",   WIDTH'(tmo),   WIDTH'(m_tmo));
    check("out",   out,           e_out);
  endtask

  bit prev_valid = 1'b0;

  // One clock: DUT and model both see the inputs present at the edge; compare 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    cycle++;
    compare_all();
    if (valid && !prev_valid) $display("[TB] cycle %0d: grant to requester %0d", cycle, sel);
    if (tmo) $display("[TB] cycle %0d: forced release", cycle);
    prev_valid = valid;
  endtask

  task automatic new_data();
    for (int k = 0; k < 4; k++) in[k] = {$urandom(), $urandom()};
  endtask

  int order[$];
  int age;
  logic [3:0] exp_tmo_gnt [12];
  bit         exp_tmo_tmo [12];

  initial begin
    reset = 1'b1; req = 4'b0000; done = 4'b0000;
    new_data();

    // Reset state
    step(); step();
    check("rst_gnt",   WIDTH'(gnt),   WIDTH'(4'b0000));
    check("rst_valid", WIDTH'(valid), WIDTH'(1'b0));
    check("rst_sel",   WIDTH'(sel),   WIDTH'(2'd0));
    check("rst_tmo",   WIDTH'(tmo),   WIDTH'(1'b0));

    // Single requester 2, done at cycle 5
    reset = 1'b0; req = 4'b0100;
    for (int c = 0; c <= 5; c++) begin
      done = (c == 5) ? 4'b0100 : 4'b0000;
      step();
      if (c < 5) begin
        check("r2_gnt", WIDTH'(gnt), WIDTH'(4'b0100));
        check("r2_sel", WIDTH'(sel), WIDTH'(2'd2));
        check("r2_out", out, in[2]);
      end else begin
        check("r2_rel_gnt", WIDTH'(gnt), WIDTH'(4'b0000));
        check("r2_rel_out", out, WIDTH'(0));
      end
    end
    req = 4'b0000; done = 4'b0000;
    step();

    // All four requesting, done two cycles after each grant
    reset = 1'b1; step();
    reset = 1'b0; req = 4'b1111; age = 0;
    order.delete();
    for (int c = 0; c < 16; c++) begin
      bit was_valid;
      was_valid = prev_valid;
      step();
      if (valid && !was_valid) order.push_back(int'(sel));
      if (m_owner >= 0) begin
        age = (valid && !was_valid) ? 0 : age + 1;
        done = (age == 1) ? (4'b0001 << m_owner) : 4'b0000;
      end else begin
        done = 4'b0000;
      end
      if (c % 4 == 3) new_data();
    end
    begin
      int exp_order[5] = '{0, 1, 2, 3, 0};
      check("rr_count", WIDTH'(order.size() >= 5), WIDTH'(1'b1));
      for (int i = 0; i < 5; i++)
        check("rr_order", WIDTH'(i < order.size() ? order[i] : 9), WIDTH'(exp_order[i]));
    end
    req = 4'b0000; done = 4'b0000;
    step();

    // Owner 1 unaffected by non-owner done/req activity; ptr still moves to 2
    reset = 1'b1; step();
    reset = 1'b0; req = 4'b0010; step();
    for (int i = 0; i < 6; i++) begin
      req  = (i % 2) ? 4'b0011 : 4'b0010;
      done = (i % 2) ? 4'b1000 : 4'b0000;
      step();
      check("own1_gnt", WIDTH'(gnt), WIDTH'(4'b0010));
    end
    req = 4'b0010; done = 4'b0010; step();
    check("own1_rel", WIDTH'(valid), WIDTH'(1'b0));
    req = 4'b0111; done = 4'b0000; step();
    check("own1_next_sel", WIDTH'(sel), WIDTH'(2'd2));
    req = 4'b0000; step(); step();

    // Reset in the middle of a grant to requester 3
    reset = 1'b1; step();
    reset = 1'b0; req = 4'b1000; step(); step(); step();
    check("r3_gnt", WIDTH'(gnt), WIDTH'(4'b1000));
    reset = 1'b1; step();
    check("r3_rst_gnt",   WIDTH'(gnt),   WIDTH'(4'b0000));
    check("r3_rst_valid", WIDTH'(valid), WIDTH'(1'b0));
    check("r3_rst_sel",   WIDTH'(sel),   WIDTH'(2'd0));
    check("r3_rst_tmo",   WIDTH'(tmo),   WIDTH'(1'b0));
    step();
    check("r3_rst_hold", WIDTH'(valid), WIDTH'(1'b0));
    reset = 1'b0; step();
    check("r3_regrant", WIDTH'(gnt), WIDTH'(4'b1000));
    req = 4'b0000; step();

    // Two requesters, no done: timeout alternation when enabled, else owner 0 holds
    reset = 1'b1; step();
    reset = 1'b0; req = 4'b0011;
    for (int e = 0; e < 12; e++) begin
      exp_tmo_tmo[e] = 1'b0;
      if (!TMO_EN)      exp_tmo_gnt[e] = 4'b0001;
      else if (e <= 3)  exp_tmo_gnt[e] = 4'b0001;
      else if (e == 4)  begin exp_tmo_gnt[e] = 4'b0000; exp_tmo_tmo[e] = 1'b1; end
      else if (e <= 8)  exp_tmo_gnt[e] = 4'b0010;
      else if (e == 9)  begin exp_tmo_gnt[e] = 4'b0000; exp_tmo_tmo[e] = 1'b1; end
      else              exp_tmo_gnt[e] = 4'b0001;
    end
    for (int e = 0; e < 12; e++) begin
      step();
      check("hold2_gnt", WIDTH'(gnt), WIDTH'(exp_tmo_gnt[e]));
      check("hold2_tmo", WIDTH'(tmo), WIDTH'(exp_tmo_tmo[e]));
    end
    req = 4'b0000; step(); step();

    // done coinciding with the timeout edge is a normal release
    reset = 1'b1; step();
    reset = 1'b0; req = 4'b0011;
    for (int e = 0; e <= 4; e++) begin
      done = (e == 4) ? 4'b0001 : 4'b0000;
      step();
    end
    check("done_tmo_gnt", WIDTH'(gnt), WIDTH'(TMO_EN ? 4'b0000 : 4'b0000));
    check("done_tmo_tmo", WIDTH'(tmo), WIDTH'(1'b0));
    req = 4'b0000; done = 4'b0000; step(); step();

    // Lone requester held well past MAX_HOLD and counter saturation
    reset = 1'b1; step();
    reset = 1'b0; req = 4'b0001;
    for (int e = 0; e < 270; e++) begin
      step();
      if (e % 20 == 0) begin
        check("solo_gnt", WIDTH'(gnt), WIDTH'(4'b0001));
        check("solo_tmo", WIDTH'(tmo), WIDTH'(1'b0));
      end
    end
    req = 4'b0000; step(); step();

    // Mixed pseudo-random traffic checked cycle by cycle against the model
    for (int e = 0; e < 300; e++) begin
      req   = 4'($urandom_range(0, 15));
      done  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      reset = ($urandom_range(0, 60) == 0);
      if (e % 7 == 0) new_data();
      step();
    end
    reset = 1'b0; req = 4'b0000; done = 4'b0000;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
